// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants, address-width helper and word/address
//                typedefs for the scoreboarded register file.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int c_xlen_default  = 32;
  localparam int c_nregs_default = 32;

  // Address width needed to index a register file of nregs entries.
  function automatic int calc_aw(input int nregs);
    return $clog2(nregs);
  endfunction

  typedef logic [c_xlen_default-1:0]               word_t;
  typedef logic [calc_aw(c_nregs_default)-1:0]     reg_addr_t;

endpackage
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb_if
//  Description : Read/write/reserve bus of the scoreboarded register file.
//                master = requester side, slave = register file side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = c_xlen_default,
  parameter int NREGS = c_nregs_default,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  localparam int c_aw = calc_aw(NREGS);

  logic [NRD*c_aw-1:0] ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      we;
  logic [NWR*c_aw-1:0] wa;
  logic [NWR*XLEN-1:0] wd;
  logic                rsv_en;
  logic [c_aw-1:0]     rsv_addr;
  logic                flush;
  logic [c_aw:0]       pend_cnt;
  logic                rsv_err;

  modport master (
    output ra, we, wa, wd, rsv_en, rsv_addr, flush,
    input  rd, rd_busy, pend_cnt, rsv_err
  );

  modport slave (
    input  ra, we, wa, wd, rsv_en, rsv_addr, flush,
    output rd, rd_busy, pend_cnt, rsv_err
  );

endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Per-register busy bits, registered busy count and
//                double-reserve error pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = c_nregs_default,
  parameter int NWR   = 1,
  parameter int AW    = calc_aw(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NWR-1:0]   we,
  input  logic [NWR*AW-1:0] wa,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             flush,
  output logic [NREGS-1:0] busy,
  output logic [AW:0]      pend_cnt,
  output logic             rsv_err
);

  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_pend_cnt;
  logic             r_rsv_err;

  logic [NREGS-1:0] w_clr;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_busy_nxt;
  logic [AW:0]      w_cnt;
  logic             w_err_nxt;

  // Next busy vector: reserve beats write-clear, flush beats both; x0 never busy.
  always_comb begin
    w_clr = '0;
    w_set = '0;
    for (int w = 0; w < NWR; w++) begin
      if (we[w] && (wa[w*AW +: AW] != '0)) begin
        w_clr[wa[w*AW +: AW]] = 1'b1;
      end
    end
    if (rsv_en && (rsv_addr != '0)) begin
      w_set[rsv_addr] = 1'b1;
    end
    w_busy_nxt    = flush ? '0 : ((r_busy & ~w_clr) | w_set);
    w_busy_nxt[0] = 1'b0;
    w_cnt = '0;
    for (int r = 0; r < NREGS; r++) begin
      w_cnt = w_cnt + (AW+1)'(w_busy_nxt[r]);
    end
    // Error only when the target stays busy from an older producer.
    w_err_nxt = !flush && ((w_set & r_busy & ~w_clr) != '0);
  end

  // Scoreboard state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_pend_cnt <= '0;
      r_rsv_err  <= 1'b0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_pend_cnt <= w_cnt;
      r_rsv_err  <= w_err_nxt;
    end
  end

  assign busy     = r_busy;
  assign pend_cnt = r_pend_cnt;
  assign rsv_err  = r_rsv_err;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : Multi-port register file (x0 hardwired to zero) with
//                optional write-to-read bypass and a busy scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = c_xlen_default,
  parameter int NREGS  = c_nregs_default,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_sb_if.slave  bus
);

  localparam int c_aw = calc_aw(NREGS);

  logic [XLEN-1:0]     r_mem [NREGS];
  logic [NREGS-1:0]    w_busy;
  logic [NRD*XLEN-1:0] w_rd;
  logic [NRD-1:0]      w_rd_busy;
  logic [c_aw-1:0]     w_ra;
  logic [XLEN-1:0]     w_word;
  logic                w_pb;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .AW    (c_aw)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (bus.we),
    .wa       (bus.wa),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .flush    (bus.flush),
    .busy     (w_busy),
    .pend_cnt (bus.pend_cnt),
    .rsv_err  (bus.rsv_err)
  );

  // Storage: later write ports overwrite earlier ones; x0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        r_mem[r] <= '0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (bus.we[w] && (bus.wa[w*c_aw +: c_aw] != '0)) begin
          r_mem[bus.wa[w*c_aw +: c_aw]] <= bus.wd[w*XLEN +: XLEN];
        end
      end
    end
  end

  // Combinational read with optional forwarding; highest matching write port wins.
  always_comb begin
    w_rd      = '0;
    w_rd_busy = '0;
    w_ra      = '0;
    w_word    = '0;
    w_pb      = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      w_ra   = bus.ra[p*c_aw +: c_aw];
      w_word = (w_ra == '0) ? '0 : r_mem[w_ra];
      w_pb   = w_busy[w_ra];
      if ((BYPASS != 0) && (w_ra != '0)) begin
        for (int w = 0; w < NWR; w++) begin
          if (bus.we[w] && (bus.wa[w*c_aw +: c_aw] == w_ra)) begin
            w_word = bus.wd[w*XLEN +: XLEN];
            w_pb   = 1'b0;
          end
        end
      end
      w_rd[p*XLEN +: XLEN] = w_word;
      w_rd_busy[p]         = w_pb;
    end
  end

  assign bus.rd      = w_rd;
  assign bus.rd_busy = w_rd_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_sb
//  Description : Directed self-checking bench for regfile_sb. Instance A:
//                NWR=2 with bypass; instance B: NWR=1 without bypass.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec;
  int   n_err;

  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) ifa ();
  regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1)) ifb ();

  regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ifa.we     = '0;
    ifa.wa     = '0;
    ifa.wd     = '0;
    ifa.rsv_en = 1'b0;
    ifa.rsv_addr = '0;
    ifa.flush  = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle_a();
    ifa.ra = '0;
    ifb.ra = '0; ifb.we = '0; ifb.wa = '0; ifb.wd = '0;
    ifb.rsv_en = 1'b0; ifb.rsv_addr = '0; ifb.flush = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Reset state on every address
    for (int a = 0; a < 32; a++) begin
      ifa.ra = {5'(a), 5'(a)};
      #1;
      check("reset_rd", 64'(ifa.rd), 64'h0);
      check("reset_rd_busy", 64'(ifa.rd_busy), 64'h0);
    end
    check("reset_pend_cnt", 64'(ifa.pend_cnt), 64'h0);
    check("reset_rsv_err", 64'(ifa.rsv_err), 64'h0);

    // Write x5 with same-cycle read: bypass vs. no bypass
    ifa.we = 2'b01; ifa.wa = {5'd0, 5'd5}; ifa.wd = {32'h0, 32'hDEADBEEF}; ifa.ra = {5'd0, 5'd5};
    ifb.we = 1'b1;  ifb.wa = 5'd5;         ifb.wd = 32'hDEADBEEF;         ifb.ra = {5'd0, 5'd5};
    #1;
    check("bypass_a_same_cycle", 64'(ifa.rd[31:0]), 64'hDEADBEEF);
    check("nobypass_b_same_cycle", 64'(ifb.rd[31:0]), 64'h0);
    tick();
    idle_a(); ifb.we = 1'b0;
    #1;
    check("a_x5_stored", 64'(ifa.rd[31:0]), 64'hDEADBEEF);
    check("b_x5_next_cycle", 64'(ifb.rd[31:0]), 64'hDEADBEEF);

    // Writes to x0 are ignored and never forwarded
    ifa.we = 2'b01; ifa.wa = {5'd0, 5'd0}; ifa.wd = {32'h0, 32'h1234}; ifa.ra = {5'd0, 5'd0};
    #1;
    check("x0_write_same_cycle", 64'(ifa.rd[31:0]), 64'h0);
    tick();
    idle_a();
    #1;
    check("x0_write_after", 64'(ifa.rd[31:0]), 64'h0);

    // Both write ports hit x7: port 1 wins for bypass and storage
    ifa.we = 2'b11; ifa.wa = {5'd7, 5'd7}; ifa.wd = {32'h2222, 32'h1111}; ifa.ra = {5'd7, 5'd0};
    #1;
    check("dual_write_bypass", 64'(ifa.rd[63:32]), 64'h2222);
    tick();
    idle_a();
    #1;
    check("dual_write_stored", 64'(ifa.rd[63:32]), 64'h2222);

    // Reserve x3, x4
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd3;
    tick();
    ifa.rsv_addr = 5'd4;
    tick();
    idle_a();
    ifa.ra = {5'd4, 5'd3};
    #1;
    check("rsv2_pend_cnt", 64'(ifa.pend_cnt), 64'd2);
    check("rsv2_rd_busy", 64'(ifa.rd_busy), 64'b11);
    check("rsv2_rsv_err", 64'(ifa.rsv_err), 64'h0);
    // Writing x3 forwards data and masks its busy flag this cycle
    ifa.we = 2'b01; ifa.wa = {5'd0, 5'd3}; ifa.wd = {32'h0, 32'hAAAA};
    #1;
    check("write_x3_rd_busy", 64'(ifa.rd_busy), 64'b10);
    check("write_x3_bypass", 64'(ifa.rd[31:0]), 64'hAAAA);
    tick();
    idle_a();
    #1;
    check("write_x3_pend_cnt", 64'(ifa.pend_cnt), 64'd1);
    check("write_x3_rd_busy_after", 64'(ifa.rd_busy), 64'b10);
    check("write_x3_stored", 64'(ifa.rd[31:0]), 64'hAAAA);
    // Re-reserve busy x4 -> one-cycle error pulse
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd4;
    tick();
    idle_a();
    #1;
    check("rerSV_err_pulse", 64'(ifa.rsv_err), 64'h1);
    check("rersv_pend_cnt", 64'(ifa.pend_cnt), 64'd1);
    tick();
    check("rersv_err_cleared", 64'(ifa.rsv_err), 64'h0);
    check("rersv_pend_cnt_hold", 64'(ifa.pend_cnt), 64'd1);

    // Reserve and write x9 together: stays busy
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd9;
    ifa.we = 2'b01; ifa.wa = {5'd0, 5'd9}; ifa.wd = {32'h0, 32'h99};
    tick();
    idle_a();
    ifa.ra = {5'd0, 5'd9};
    #1;
    check("rsv_wr_x9_pend_cnt", 64'(ifa.pend_cnt), 64'd2);
    check("rsv_wr_x9_busy", 64'(ifa.rd_busy[0]), 64'h1);
    check("rsv_wr_x9_data", 64'(ifa.rd[31:0]), 64'h99);
    check("rsv_wr_x9_err", 64'(ifa.rsv_err), 64'h0);

    // Re-reserve busy x12 while a write clears it: no error, busy kept
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd12;
    tick();
    ifa.we = 2'b10; ifa.wa = {5'd12, 5'd0}; ifa.wd = {32'hC, 32'h0};
    tick();
    idle_a();
    ifa.ra = {5'd0, 5'd12};
    #1;
    check("rsv_wr_busy_x12_err", 64'(ifa.rsv_err), 64'h0);
    check("rsv_wr_busy_x12_pend", 64'(ifa.pend_cnt), 64'd3);
    check("rsv_wr_busy_x12_busy", 64'(ifa.rd_busy[0]), 64'h1);

    // Flush overrides a reserve of x10; the data write still lands
    ifa.flush = 1'b1; ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd10;
    ifa.we = 2'b01; ifa.wa = {5'd0, 5'd10}; ifa.wd = {32'h0, 32'h10};
    tick();
    idle_a();
    #1;
    check("flush_pend_cnt", 64'(ifa.pend_cnt), 64'd0);
    check("flush_rsv_err", 64'(ifa.rsv_err), 64'h0);
    for (int a = 0; a < 32; a++) begin
      ifa.ra = {5'(a), 5'(a)};
      #1;
      check("flush_rd_busy", 64'(ifa.rd_busy), 64'h0);
    end
    ifa.ra = {5'd0, 5'd10};
    #1;
    check("flush_x10_data", 64'(ifa.rd[31:0]), 64'h10);

    // Reserving x0 does nothing
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd0;
    tick();
    idle_a();
    check("rsv_x0_pend_cnt", 64'(ifa.pend_cnt), 64'd0);

    // Flush suppresses the double-reserve error
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd11;
    tick();
    ifa.flush = 1'b1;
    tick();
    idle_a();
    check("flush_supp_err", 64'(ifa.rsv_err), 64'h0);
    check("flush_supp_pend", 64'(ifa.pend_cnt), 64'd0);

    // Reserve every register: count tops out at NREGS-1
    for (int r = 1; r < 32; r++) begin
      ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'(r);
      tick();
    end
    ifa.rsv_addr = 5'd0;
    tick();
    idle_a();
    check("all_rsv_pend_cnt", 64'(ifa.pend_cnt), 64'd31);
    check("all_rsv_err", 64'(ifa.rsv_err), 64'h0);
    ifa.flush = 1'b1;
    tick();
    idle_a();
    check("all_rsv_flush", 64'(ifa.pend_cnt), 64'd0);

    // Asynchronous reset between edges with x5 busy
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd5;
    tick();
    idle_a();
    ifa.ra = {5'd0, 5'd5};
    #1;
    check("pre_rst_x5_data", 64'(ifa.rd[31:0]), 64'hDEADBEEF);
    check("pre_rst_x5_busy", 64'(ifa.rd_busy[0]), 64'h1);
    check("pre_rst_pend", 64'(ifa.pend_cnt), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_x5_data", 64'(ifa.rd[31:0]), 64'h0);
    check("async_rst_busy", 64'(ifa.rd_busy), 64'h0);
    check("async_rst_pend", 64'(ifa.pend_cnt), 64'd0);
    check("async_rst_err", 64'(ifa.rsv_err), 64'h0);
    check("async_rst_b_x5", 64'(ifb.rd[31:0]), 64'h0);
    // Activity held during reset is discarded
    ifa.rsv_en = 1'b1; ifa.rsv_addr = 5'd6;
    ifa.we = 2'b01; ifa.wa = {5'd0, 5'd6}; ifa.wd = {32'h0, 32'h66};
    @(posedge clk);
    #2;
    idle_a();
    #1;
    rst_n = 1'b1;
    tick();
    ifa.ra = {5'd0, 5'd6};
    #1;
    check("post_rst_x6_data", 64'(ifa.rd[31:0]), 64'h0);
    check("post_rst_x6_busy", 64'(ifa.rd_busy), 64'h0);
    check("post_rst_pend", 64'(ifa.pend_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
